// File: rtl/pif_pwm_capture.sv
// -----------------------------------------------------------------------------
// pif_pwm_capture
//   Measures the high time and the rising-edge-to-rising-edge period of an
//   asynchronous PWM / LED-drive signal, in Clk cycles, and holds the last
//   result behind a valid/ack handshake.
//
//   Optional feature macro: PIF_PWM_CAPTURE_GLITCH_FILTER_EN
//     When defined, a 3-sample majority-free glitch filter follows the
//     synchronizer.  Pulses of 1 or 2 cycles are ignored and latency grows
//     by 2 cycles.  When undefined, the synchronized level is used directly.
//
// Ports
//   Clk         : system clock, all state updates on its rising edge
//   sys_rst     : asynchronous, active-low reset
//   pwm_in      : asynchronous signal under measurement
//   enable      : measurement runs while high
//   ack         : consumer acknowledge of the held result
//   high_cnt    : high time of the last completed period (CW bits)
//   period_cnt  : rise-to-rise period of the last completed period (CW bits)
//   valid       : held result not yet consumed
//   overrun     : sticky, a result was dropped while valid was high
//   stuck       : no edge within 2^CW-1 cycles
//   stuck_level : synchronized level of pwm_in when stuck was raised
// -----------------------------------------------------------------------------
module pif_pwm_capture #(
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          sys_rst,
  input  logic          pwm_in,
  input  logic          enable,
  input  logic          ack,
  output logic [CW-1:0] high_cnt,
  output logic [CW-1:0] period_cnt,
  output logic          valid,
  output logic          overrun,
  output logic          stuck,
  output logic          stuck_level
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_r;
  state_t        state_s;
  logic          sync1_r;
  logic          sync2_r;
  logic          level_s;
  logic          level_prev_r;
  logic          rise_s;
  logic          fall_s;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] high_hold_r;
  logic          cnt_load_s;
  logic          cnt_inc_s;
  logic          high_cap_s;
  logic          publish_s;
  logic          stuck_set_s;
  logic          stuck_clr_s;

  // Two-flop synchronizer for the asynchronous input
  always_ff @(posedge Clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pwm_in;
      sync2_r <= sync1_r;
    end
  end

`ifdef PIF_PWM_CAPTURE_GLITCH_FILTER_EN
  logic filt_d1_r;
  logic filt_d2_r;
  logic filt_lvl_r;

  // Sample history of the synchronized level and the held filtered level
  always_ff @(posedge Clk or negedge sys_rst) begin
    if (!sys_rst) begin
      filt_d1_r  <= 1'b0;
      filt_d2_r  <= 1'b0;
      filt_lvl_r <= 1'b0;
    end else begin
      filt_d1_r  <= sync2_r;
      filt_d2_r  <= filt_d1_r;
      filt_lvl_r <= level_s;
    end
  end

  // Level follows the input only once three consecutive samples agree; the
  // decision is combinational from registers so latency grows by exactly 2
  always_comb begin
    level_s = filt_lvl_r;
    if ((sync2_r == filt_d1_r) && (filt_d1_r == filt_d2_r)) begin
      level_s = sync2_r;
    end else begin
      level_s = filt_lvl_r;
    end
  end
`else
  // Unfiltered: the measured level is the synchronized sample
  always_comb begin
    level_s = sync2_r;
  end
`endif

  // Edge history of the measured level
  always_ff @(posedge Clk or negedge sys_rst) begin
    if (!sys_rst) begin
      level_prev_r <= 1'b0;
    end else begin
      level_prev_r <= level_s;
    end
  end

  // Edge detection
  always_comb begin
    rise_s = level_s & ~level_prev_r;
    fall_s = ~level_s & level_prev_r;
  end

  // FSM state register
  always_ff @(posedge Clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state and datapath controls; timeout wins over a coincident edge
  always_comb begin
    state_s     = state_r;
    cnt_load_s  = 1'b0;
    cnt_inc_s   = 1'b0;
    high_cap_s  = 1'b0;
    publish_s   = 1'b0;
    stuck_set_s = 1'b0;
    stuck_clr_s = enable & (rise_s | fall_s);
    if (!enable) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (rise_s) begin
            state_s    = HIGH;
            cnt_load_s = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end
        HIGH: begin
          if (cnt_r == CNT_MAX) begin
            state_s     = IDLE;
            stuck_set_s = 1'b1;
          end else if (fall_s) begin
            state_s    = LOW;
            high_cap_s = 1'b1;
            cnt_inc_s  = 1'b1;
          end else begin
            cnt_inc_s = 1'b1;
          end
        end
        LOW: begin
          if (cnt_r == CNT_MAX) begin
            state_s     = IDLE;
            stuck_set_s = 1'b1;
          end else if (rise_s) begin
            state_s    = HIGH;
            publish_s  = 1'b1;
            cnt_load_s = 1'b1;
          end else begin
            cnt_inc_s = 1'b1;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Period counter (restarts at 1 on each rise, saturates) and high-time hold
  always_ff @(posedge Clk or negedge sys_rst) begin
    if (!sys_rst) begin
      cnt_r       <= {CW{1'b0}};
      high_hold_r <= {CW{1'b0}};
    end else begin
      if (cnt_load_s) begin
        cnt_r <= CNT_ONE;
      end else if (cnt_inc_s && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      if (high_cap_s) begin
        high_hold_r <= cnt_r;
      end else begin
        high_hold_r <= high_hold_r;
      end
    end
  end

  // Result registers and valid/ack/overrun handshake
  always_ff @(posedge Clk or negedge sys_rst) begin
    if (!sys_rst) begin
      high_cnt   <= {CW{1'b0}};
      period_cnt <= {CW{1'b0}};
      valid      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (publish_s) begin
        if (!valid || ack) begin
          high_cnt   <= high_hold_r;
          period_cnt <= cnt_r;
          valid      <= 1'b1;
        end else begin
          // Consumer has not taken the previous result: drop the new one
          overrun <= 1'b1;
        end
      end else if (ack && valid) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end else begin
        valid   <= valid;
        overrun <= overrun;
      end
    end
  end

  // Stuck detection flag and the level it was raised at
  always_ff @(posedge Clk or negedge sys_rst) begin
    if (!sys_rst) begin
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      if (stuck_set_s) begin
        stuck       <= 1'b1;
        stuck_level <= level_s;
      end else if (stuck_clr_s) begin
        stuck <= 1'b0;
      end else begin
        stuck <= stuck;
      end
    end
  end

endmodule

// File: tb/tb_pif_pwm_capture.sv
// -----------------------------------------------------------------------------
// tb_pif_pwm_capture
//   Directed bench for pif_pwm_capture.  One instance with CW=16 covers the
//   measurement and handshake behaviour; a second with CW=8 covers the stuck
//   timeout.  Inputs change on the falling clock edge, outputs are sampled on
//   the falling edge.  A level held for n falling-edge intervals is seen by
//   exactly n rising edges, so it measures as n cycles.
// -----------------------------------------------------------------------------
module tb_pif_pwm_capture;

`ifdef PIF_PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic        Clk;
  logic        sys_rst;
  logic        pwm_in;
  logic        enable;
  logic        ack;
  logic [15:0] high_cnt;
  logic [15:0] period_cnt;
  logic        valid;
  logic        overrun;
  logic        stuck;
  logic        stuck_level;
  logic [7:0]  h8;
  logic [7:0]  p8;
  logic        v8;
  logic        o8;
  logic        s8;
  logic        sl8;

  int errors;
  int checks;

  pif_pwm_capture #(.CW(16)) dut (
    .Clk        (Clk),
    .sys_rst    (sys_rst),
    .pwm_in     (pwm_in),
    .enable     (enable),
    .ack        (ack),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .valid      (valid),
    .overrun    (overrun),
    .stuck      (stuck),
    .stuck_level(stuck_level)
  );

  pif_pwm_capture #(.CW(8)) dut8 (
    .Clk        (Clk),
    .sys_rst    (sys_rst),
    .pwm_in     (pwm_in),
    .enable     (enable),
    .ack        (ack),
    .high_cnt   (h8),
    .period_cnt (p8),
    .valid      (v8),
    .overrun    (o8),
    .stuck      (s8),
    .stuck_level(sl8)
  );

  // Clock generation
  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Single comparison point
  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Hold pwm_in at lvl for n clock cycles
  task automatic pwm_phase(input logic lvl, input int n);
    pwm_in = lvl;
    repeat (n) @(negedge Clk);
  endtask

  task automatic do_reset();
    sys_rst = 1'b0;
    pwm_in  = 1'b0;
    ack     = 1'b0;
    repeat (2) @(negedge Clk);
    sys_rst = 1'b1;
    @(negedge Clk);
  endtask

  // Watchdog
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout, expected end of run");
    $fatal(1, "bench timeout");
  end

  initial begin
    int n;
    errors  = 0;
    checks  = 0;
    sys_rst = 1'b0;
    pwm_in  = 1'b0;
    enable  = 1'b0;
    ack     = 1'b0;
    repeat (3) @(negedge Clk);

    // ---- reset state
    check_val("rst_high",   32'(high_cnt),    32'd0);
    check_val("rst_period", 32'(period_cnt),  32'd0);
    check_val("rst_valid",  32'(valid),       32'd0);
    check_val("rst_ovr",    32'(overrun),     32'd0);
    check_val("rst_stuck",  32'(stuck),       32'd0);
    check_val("rst_slvl",   32'(stuck_level), 32'd0);
    check_val("rst8_all",   32'({h8, p8, v8, o8, s8, sl8}), 32'd0);
    sys_rst = 1'b1;
    enable  = 1'b1;
    @(negedge Clk);

    // ---- 50/50 square wave, no ack
    pwm_phase(1'b0, 10);
    pwm_phase(1'b1, 50);
    pwm_phase(1'b0, 50);
    pwm_phase(1'b1, LAT);
    check_val("t1_valid_early", 32'(valid), 32'd0);
    pwm_phase(1'b1, 1);
    check_val("t1_valid",  32'(valid),      32'd1);
    check_val("t1_high",   32'(high_cnt),   32'd50);
    check_val("t1_period", 32'(period_cnt), 32'd100);
    check_val("t1_ovr0",   32'(overrun),    32'd0);
    pwm_phase(1'b1, 50 - LAT - 1);
    pwm_phase(1'b0, 50);
    pwm_phase(1'b1, LAT + 1);
    check_val("t1_ovr1", 32'(overrun), 32'd1);
    // a differently shaped period must also be dropped
    pwm_phase(1'b1, 20 - LAT - 1);
    pwm_phase(1'b0, 50);
    pwm_phase(1'b1, LAT + 1);
    check_val("t1_keep_high",   32'(high_cnt),   32'd50);
    check_val("t1_keep_period", 32'(period_cnt), 32'd100);
    check_val("t1_keep_valid",  32'(valid),      32'd1);
    ack = 1'b1;
    @(negedge Clk);
    ack = 1'b0;
    check_val("t1_ack_valid", 32'(valid),   32'd0);
    check_val("t1_ack_ovr",   32'(overrun), 32'd0);
    ack = 1'b1;
    @(negedge Clk);
    ack = 1'b0;
    check_val("t1_ack_idle", 32'(valid), 32'd0);

    // ---- 30/70 with ack on every result
    do_reset();
    pwm_phase(1'b0, 10);
    pwm_phase(1'b1, 30);
    pwm_phase(1'b0, 70);
    for (int k = 0; k < 3; k++) begin
      pwm_phase(1'b1, LAT + 1);
      check_val("t2_valid",  32'(valid),      32'd1);
      check_val("t2_high",   32'(high_cnt),   32'd30);
      check_val("t2_period", 32'(period_cnt), 32'd100);
      check_val("t2_ovr",    32'(overrun),    32'd0);
      ack = 1'b1;
      pwm_phase(1'b1, 1);
      ack = 1'b0;
      check_val("t2_acked", 32'(valid), 32'd0);
      pwm_phase(1'b1, 30 - LAT - 2);
      pwm_phase(1'b0, 70);
    end
    // leave this result unconsumed, then ack exactly at the next publish
    pwm_phase(1'b1, LAT + 1);
    check_val("t2_hold_valid", 32'(valid), 32'd1);
    pwm_phase(1'b1, 30 - LAT - 1);
    pwm_phase(1'b0, 70);
    pwm_phase(1'b1, LAT);
    ack = 1'b1;
    pwm_phase(1'b1, 1);
    ack = 1'b0;
    check_val("t2_coinc_valid",  32'(valid),      32'd1);
    check_val("t2_coinc_ovr",    32'(overrun),    32'd0);
    check_val("t2_coinc_high",   32'(high_cnt),   32'd30);
    check_val("t2_coinc_period", 32'(period_cnt), 32'd100);
    ack = 1'b1;
    pwm_phase(1'b1, 1);
    ack = 1'b0;
    check_val("t2_final_ack", 32'(valid), 32'd0);

    // ---- stuck high on the CW=8 instance
    do_reset();
    pwm_phase(1'b0, 10);
    pwm_in = 1'b1;
    n = 0;
    while (s8 !== 1'b1 && n < 1000) begin
      @(negedge Clk);
      n++;
    end
    check_val("t3_stuck_time", 32'(n),           32'(LAT + 256));
    check_val("t3_stuck",      32'(s8),          32'd1);
    check_val("t3_stuck_lvl",  32'(sl8),         32'd1);
    check_val("t3_no_valid",   32'(v8),          32'd0);
    check_val("t3_cw16_quiet", 32'(stuck),       32'd0);
    pwm_phase(1'b1, 20);
    check_val("t3_stuck_hold", 32'(s8), 32'd1);
    pwm_phase(1'b0, LAT);
    check_val("t3_stuck_pre_clr", 32'(s8), 32'd1);
    pwm_phase(1'b0, 1);
    check_val("t3_stuck_clr", 32'(s8), 32'd0);

    // ---- enable dropped mid-HIGH
    do_reset();
    pwm_phase(1'b0, 10);
    pwm_phase(1'b1, 20);
    enable = 1'b0;
    pwm_phase(1'b1, 10);
    enable = 1'b1;
    pwm_phase(1'b1, 20);
    pwm_phase(1'b0, 50);
    pwm_phase(1'b1, LAT + 1);
    check_val("t4_no_result", 32'(valid), 32'd0);
    pwm_phase(1'b1, 50 - LAT - 1);
    pwm_phase(1'b0, 50);
    pwm_phase(1'b1, LAT + 1);
    check_val("t4_valid",  32'(valid),      32'd1);
    check_val("t4_high",   32'(high_cnt),   32'd50);
    check_val("t4_period", 32'(period_cnt), 32'd100);

    // ---- reset pulse mid-LOW with a result held
    pwm_phase(1'b1, 50 - LAT - 1);
    pwm_phase(1'b0, 20);
    sys_rst = 1'b0;
    #1;
    check_val("t5_rst_valid",  32'(valid),      32'd0);
    check_val("t5_rst_high",   32'(high_cnt),   32'd0);
    check_val("t5_rst_period", 32'(period_cnt), 32'd0);
    @(negedge Clk);
    sys_rst = 1'b1;
    pwm_phase(1'b0, 30);
    pwm_phase(1'b1, LAT + 1);
    check_val("t5_no_spurious", 32'(valid), 32'd0);
    pwm_phase(1'b1, 50 - LAT - 1);
    pwm_phase(1'b0, 50);
    pwm_phase(1'b1, LAT + 1);
    check_val("t5_valid",  32'(valid),      32'd1);
    check_val("t5_high",   32'(high_cnt),   32'd50);
    check_val("t5_period", 32'(period_cnt), 32'd100);

    // ---- 2-cycle glitch inside a 40/60 wave
    do_reset();
    pwm_phase(1'b0, 10);
    pwm_phase(1'b1, 40);
    pwm_phase(1'b0, 20);
    pwm_phase(1'b1, 2);
`ifdef PIF_PWM_CAPTURE_GLITCH_FILTER_EN
    pwm_phase(1'b0, 38);
    pwm_phase(1'b1, LAT + 1);
    check_val("t6_valid",  32'(valid),      32'd1);
    check_val("t6_high",   32'(high_cnt),   32'd40);
    check_val("t6_period", 32'(period_cnt), 32'd100);
`else
    pwm_phase(1'b0, 1);
    check_val("t6_pre_valid",  32'(valid),      32'd1);
    check_val("t6_pre_high",   32'(high_cnt),   32'd40);
    check_val("t6_pre_period", 32'(period_cnt), 32'd60);
    ack = 1'b1;
    pwm_phase(1'b0, 1);
    ack = 1'b0;
    pwm_phase(1'b0, 36);
    pwm_phase(1'b1, LAT + 1);
    check_val("t6_valid",  32'(valid),      32'd1);
    check_val("t6_high",   32'(high_cnt),   32'd2);
    check_val("t6_period", 32'(period_cnt), 32'd40);
    check_val("t6_ovr",    32'(overrun),    32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
